iq_stream_arbiter: RTL and testbench

- Shares the single 32-bit IQ read path toward the STM32 parallel-bus interface between two producers: the spectrum IQ stream and the voice IQ stream.
- Buffers each stream in a small FIFO and arbitrates them with voice priority, backed by a starvation guard for the spectrum stream.
- Presents one registered sample at a time, with a valid/ready handshake, to the bus interface's RX IQ read sequence.
- Counts dropped samples for the MCU status read.

---
 rtl/iq_stream_arbiter_pkg.sv | 22 ++
 rtl/iq_sync_fifo.sv | 55 +++++
 rtl/iq_stream_arbiter.sv | 128 ++++++++++++
 tb/tb_iq_stream_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/iq_stream_arbiter_pkg.sv
// Shared widths, source encodings and drop-counter helpers for the IQ stream arbiter.
package iq_stream_arbiter_pkg;

  localparam int IQ_W     = 16;
  localparam int SAMPLE_W = 2 * IQ_W;

  localparam logic SRC_SPEC  = 1'b0;
  localparam logic SRC_VOICE = 1'b1;

  localparam int                DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/iq_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an occupancy count that separates full from empty.
module iq_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = mem[rd_ptr];

  // Fullness is judged before any same-edge pop, so a write into a full FIFO is lost.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_in) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iq_stream_arbiter.sv
// Voice-priority arbiter sharing the 32-bit IQ read path between the spectrum and voice streams.
//   state     | meaning
//   OUT_EMPTY | output register holds nothing; any non-empty FIFO is granted
//   OUT_HOLD  | sample presented; replaced only when out_ready=1
import iq_stream_arbiter_pkg::*;

module iq_stream_arbiter #(
  parameter int DEPTH         = 4,
  parameter int MAX_VOICE_RUN = 3
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    spec_valid,
  input  logic signed [IQ_W-1:0]  SPEC_I,
  input  logic signed [IQ_W-1:0]  SPEC_Q,
  input  logic                    voice_valid,
  input  logic signed [IQ_W-1:0]  VOICE_I,
  input  logic signed [IQ_W-1:0]  VOICE_Q,
  input  logic                    flush,
  input  logic                    clr_drop,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic                    out_src,
  output logic signed [IQ_W-1:0]  out_i,
  output logic signed [IQ_W-1:0]  out_q,
  output logic [DROP_W-1:0]       spec_drop,
  output logic [DROP_W-1:0]       voice_drop
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int RUN_W = 4;

  out_state_t          state;
  logic [RUN_W-1:0]    run;
  logic [RUN_W-1:0]    run_nxt;
  logic [SAMPLE_W-1:0] spec_dout,  voice_dout;
  logic                spec_empty, voice_empty;
  logic                spec_full,  voice_full;
  logic [CW-1:0]       spec_count, voice_count;
  logic                load_opp;
  logic                grant_any;
  logic                grant_voice;
  logic                unused_fifo_levels;

  // FIFO levels are not needed by the arbitration.
  assign unused_fifo_levels = ^{spec_count, voice_count};

  iq_sync_fifo #(.DEPTH(DEPTH), .WIDTH(SAMPLE_W)) u_spec_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .clr    (flush),
    .wr_en  (spec_valid && !flush),
    .rd_en  (grant_any && !grant_voice && !flush),
    .din    ({SPEC_I, SPEC_Q}),
    .dout   (spec_dout),
    .empty  (spec_empty),
    .full   (spec_full),
    .count  (spec_count)
  );

  iq_sync_fifo #(.DEPTH(DEPTH), .WIDTH(SAMPLE_W)) u_voice_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .clr    (flush),
    .wr_en  (voice_valid && !flush),
    .rd_en  (grant_voice && !flush),
    .din    ({VOICE_I, VOICE_Q}),
    .dout   (voice_dout),
    .empty  (voice_empty),
    .full   (voice_full),
    .count  (voice_count)
  );

  assign out_valid = (state == OUT_HOLD);
  assign load_opp  = (state == OUT_EMPTY) || out_ready;

  // Voice wins until it has taken MAX_VOICE_RUN grants in a row against a waiting spectrum.
  always_comb begin
    grant_any   = 1'b0;
    grant_voice = 1'b0;
    run_nxt     = run;
    if (load_opp) begin
      if (!voice_empty && (spec_empty || run < RUN_W'(MAX_VOICE_RUN))) begin
        grant_any   = 1'b1;
        grant_voice = 1'b1;
        run_nxt     = spec_empty ? '0 : run + 1'b1;
      end else if (!spec_empty) begin
        grant_any = 1'b1;
        run_nxt   = '0;
      end else begin
        run_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= OUT_EMPTY;
      run        <= '0;
      out_src    <= SRC_SPEC;
      out_i      <= '0;
      out_q      <= '0;
      spec_drop  <= '0;
      voice_drop <= '0;
    end else begin
      if (flush) begin
        state <= OUT_EMPTY;
        run   <= '0;
      end else if (grant_any) begin
        state   <= OUT_HOLD;
        run     <= run_nxt;
        out_src <= grant_voice ? SRC_VOICE : SRC_SPEC;
        out_i   <= grant_voice ? voice_dout[SAMPLE_W-1 -: IQ_W] : spec_dout[SAMPLE_W-1 -: IQ_W];
        out_q   <= grant_voice ? voice_dout[IQ_W-1:0] : spec_dout[IQ_W-1:0];
      end else if (load_opp) begin
        state <= OUT_EMPTY;
        run   <= run_nxt;
      end

      if (clr_drop)                              spec_drop <= '0;
      else if (spec_valid && spec_full && !flush) spec_drop <= sat_inc(spec_drop);

      if (clr_drop)                                voice_drop <= '0;
      else if (voice_valid && voice_full && !flush) voice_drop <= sat_inc(voice_drop);
    end
  end

endmodule

// File: tb/tb_iq_stream_arbiter.sv
// Directed bench for iq_stream_arbiter with an output-order scoreboard.
module tb_iq_stream_arbiter;

  logic               clk_in = 1'b0;
  logic               reset;
  logic               spec_valid;
  logic signed [15:0] SPEC_I, SPEC_Q;
  logic               voice_valid;
  logic signed [15:0] VOICE_I, VOICE_Q;
  logic               flush;
  logic               clr_drop;
  logic               out_ready;
  logic               out_valid;
  logic               out_src;
  logic signed [15:0] out_i, out_q;
  logic [7:0]         spec_drop, voice_drop;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;

  always #5 clk_in = ~clk_in;

  iq_stream_arbiter #(.DEPTH(4), .MAX_VOICE_RUN(3)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .spec_valid  (spec_valid),
    .SPEC_I      (SPEC_I),
    .SPEC_Q      (SPEC_Q),
    .voice_valid (voice_valid),
    .VOICE_I     (VOICE_I),
    .VOICE_Q     (VOICE_Q),
    .flush       (flush),
    .clr_drop    (clr_drop),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_src     (out_src),
    .out_i       (out_i),
    .out_q       (out_q),
    .spec_drop   (spec_drop),
    .voice_drop  (voice_drop)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic void push(input logic src, input logic [15:0] i, input logic [15:0] q);
    exp_q.push_back({src, i, q});
  endfunction

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && out_valid; n++) tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 64'(out_valid), 64'd0);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // A handshake consumes the held sample unless reset or flush discards it.
  always @(negedge clk_in) begin
    if (out_valid && out_ready && !reset && !flush) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_sample", 64'({out_src, out_i, out_q}), 64'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; spec_valid = 1'b0; voice_valid = 1'b0;
    SPEC_I = '0; SPEC_Q = '0; VOICE_I = '0; VOICE_Q = '0;
    flush = 1'b0; clr_drop = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_out", 64'({out_valid, out_src, out_i, out_q}), 64'd0);
    check("reset_drops", 64'({spec_drop, voice_drop}), 64'd0);

    // 1: single spectrum sample, two-edge latency, held while out_ready=0
    spec_valid = 1'b1; SPEC_I = 16'h1234; SPEC_Q = -16'sd5;
    push(1'b0, 16'h1234, 16'hFFFB);
    tick();
    spec_valid = 1'b0;
    check("t1_not_yet", 64'(out_valid), 64'd0);
    tick();
    check("t1_loaded", 64'({out_valid, out_src, out_i, out_q}), {30'd0, 1'b1, 1'b0, 16'h1234, 16'hFFFB});
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t1_hold", 64'({out_valid, out_src, out_i, out_q}), {30'd0, 1'b1, 1'b0, 16'h1234, 16'hFFFB});
    end
    drain("t1");

    // 2: starvation guard, expected grants V,V,V,S,V,S,S,S
    for (int k = 0; k < 4; k++) begin
      spec_valid  = 1'b1; SPEC_I  = 16'(16'h2000 + k); SPEC_Q  = 16'(16'h2100 + k);
      voice_valid = 1'b1; VOICE_I = 16'(16'h3000 + k); VOICE_Q = 16'(16'h3100 + k);
      tick();
    end
    spec_valid = 1'b0; voice_valid = 1'b0;
    push(1'b1, 16'h3000, 16'h3100);
    push(1'b1, 16'h3001, 16'h3101);
    push(1'b1, 16'h3002, 16'h3102);
    push(1'b0, 16'h2000, 16'h2100);
    push(1'b1, 16'h3003, 16'h3103);
    push(1'b0, 16'h2001, 16'h2101);
    push(1'b0, 16'h2002, 16'h2102);
    push(1'b0, 16'h2003, 16'h2103);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t2_no_bubble", 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b0;
    check("t2_empty_after", 64'(out_valid), 64'd0);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // 3: overflow with a pop on the last overflowing write
    for (int k = 0; k < 5; k++) begin
      voice_valid = 1'b1; VOICE_I = 16'(16'h4000 + k); VOICE_Q = 16'(16'h4100 + k);
      push(1'b1, 16'(16'h4000 + k), 16'(16'h4100 + k));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      VOICE_I = 16'(16'h4F00 + k); VOICE_Q = 16'(16'h4F10 + k);
      out_ready = (k == 2);
      tick();
    end
    voice_valid = 1'b0; out_ready = 1'b0;
    check("t3_voice_drop", 64'(voice_drop), 64'd3);
    check("t3_spec_drop", 64'(spec_drop), 64'd0);
    drain("t3");

    // 4: drop saturation and clear-wins
    for (int k = 0; k < 5; k++) begin
      spec_valid = 1'b1; SPEC_I = 16'(16'h5000 + k); SPEC_Q = 16'(16'h5100 + k);
      push(1'b0, 16'(16'h5000 + k), 16'(16'h5100 + k));
      tick();
    end
    SPEC_I = 16'h5F00; SPEC_Q = 16'h5F01;
    repeat (254) tick();
    check("t4_below_sat", 64'(spec_drop), 64'd254);
    tick();
    check("t4_at_sat", 64'(spec_drop), 64'd255);
    repeat (45) tick();
    check("t4_saturated", 64'(spec_drop), 64'd255);
    clr_drop = 1'b1;
    tick();
    clr_drop = 1'b0; spec_valid = 1'b0;
    check("t4_clr_wins", 64'(spec_drop), 64'd0);
    check("t4_clr_voice", 64'(voice_drop), 64'd0);
    drain("t4");

    // 5: flush mid-handshake
    for (int k = 0; k < 6; k++) begin
      voice_valid = 1'b1; VOICE_I = 16'(16'h6000 + k); VOICE_Q = 16'(16'h6010 + k);
      spec_valid = (k < 2); SPEC_I = 16'(16'h6100 + k); SPEC_Q = 16'(16'h6110 + k);
      tick();
    end
    voice_valid = 1'b0; spec_valid = 1'b0;
    check("t5_pre_drop", 64'(voice_drop), 64'd1);
    check("t5_pre_hold", 64'(out_valid), 64'd1);
    flush = 1'b1; spec_valid = 1'b1; SPEC_I = 16'h6F00; SPEC_Q = 16'h6F01; out_ready = 1'b1;
    tick();
    flush = 1'b0; spec_valid = 1'b0;
    check("t5_flushed", 64'(out_valid), 64'd0);
    check("t5_drops_kept", 64'({spec_drop, voice_drop}), 64'h0001);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_fifos_empty", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;

    // 6: reset mid-stream, then normal latency
    for (int k = 0; k < 2; k++) begin
      spec_valid = 1'b1; SPEC_I = 16'(16'h7000 + k); SPEC_Q = 16'(16'h7010 + k);
      tick();
    end
    spec_valid = 1'b0;
    check("t6_pre_hold", 64'(out_valid), 64'd1);
    reset = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    check("t6_reset_out", 64'({out_valid, out_src, out_i, out_q}), 64'd0);
    check("t6_reset_drops", 64'({spec_drop, voice_drop}), 64'd0);
    voice_valid = 1'b1; VOICE_I = 16'h7100; VOICE_Q = -16'sd2;
    push(1'b1, 16'h7100, 16'hFFFE);
    tick();
    voice_valid = 1'b0;
    check("t6_not_yet", 64'(out_valid), 64'd0);
    tick();
    check("t6_loaded", 64'({out_valid, out_src, out_i, out_q}), {30'd0, 1'b1, 1'b1, 16'h7100, 16'hFFFE});
    drain("t6");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
